// File: rtl/test_stream_ctrl_pkg.sv
// Shared definitions for the ECG test stream sequencer: state encoding and
// the layout of a buffered stream word ({is_cfg, last, data}).
`default_nettype none

package tb_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CFG   = 3'd1;
    localparam logic [2:0] ST_ECG   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Tag bits sit above the data field in every buffered word.
    typedef struct packed {
        logic is_cfg;
        logic last;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

`default_nettype wire

// File: rtl/test_stream_ctrl_buf.sv
// stream_buf: small synchronous FIFO with flush and occupancy count.
// Simultaneous push and pop while full is allowed.
`default_nettype none

module stream_buf #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    assign do_pop = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/test_stream_ctrl.sv
// test_stream_ctrl: streams a config range then N (or endless) ECG passes
// from synchronous-read memories onto one tagged valid/ready stream.
`default_nettype none

module test_stream_ctrl
    import tb_ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CFG_AW    = 10,
    parameter int ECG_AW    = 13,
    parameter int CFG_STR   = 0,
    parameter int CFG_END   = 799,
    parameter int ECG_STR   = 0,
    parameter int ECG_END   = 4999,
    parameter int LOOP_W    = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              test_en,
    input  logic              abort,
    input  logic [LOOP_W-1:0] loop_cnt,
    output logic              cfg_rd_en,
    output logic [CFG_AW-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_q,
    output logic              ecg_rd_en,
    output logic [ECG_AW-1:0] ecg_addr,
    input  logic [DATA_W-1:0] ecg_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_is_cfg,
    output logic              out_last,
    output logic              busy,
    output logic              test_done,
    output logic [LOOP_W-1:0] pass_cnt
);

    localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int WORD_W = DATA_W + TAG_W;

    logic [2:0]        state_q, state_d;
    logic [CFG_AW-1:0] cfg_addr_q, cfg_addr_d;
    logic [ECG_AW-1:0] ecg_addr_q, ecg_addr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_cfg_q, inflight_cfg_d;
    logic              inflight_last_q, inflight_last_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic [LOOP_W-1:0] ipass_q, ipass_d;
    logic [LOOP_W-1:0] pass_cnt_q, pass_cnt_d;

    logic              pop;
    logic              push;
    logic              credit;
    logic [CNT_W:0]    pending;
    logic [CNT_W-1:0]  occ;
    logic              buf_empty;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] head_word;
    tag_t              wr_tag;
    tag_t              head_tag;
    logic              start;
    logic              cfg_end_issue;
    logic              ecg_end_issue;
    logic              final_pass;

    // Room is judged against what the buffer will hold once the in-flight word lands.
    assign pop     = out_valid & out_ready;
    assign pending = (CNT_W+1)'(occ) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign credit  = pending < (CNT_W+1)'(BUF_DEPTH);

    assign start         = (state_q == ST_IDLE) & test_en;
    assign cfg_end_issue = cfg_rd_en & (cfg_addr_q == CFG_AW'(CFG_END));
    assign ecg_end_issue = ecg_rd_en & (ecg_addr_q == ECG_AW'(ECG_END));
    assign final_pass    = (loop_q != '0) & (ipass_q == loop_q - LOOP_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (test_en)                  state_d = ST_CFG;
                ST_CFG:   if (cfg_end_issue)            state_d = ST_ECG;
                ST_ECG:   if (ecg_end_issue && final_pass) state_d = ST_DRAIN;
                ST_DRAIN: if (buf_empty && !inflight_q) state_d = ST_DONE;
                ST_DONE:  if (!test_en)                 state_d = ST_IDLE;
                default:                                state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_rd_en = (state_q == ST_CFG) & credit;
        ecg_rd_en = (state_q == ST_ECG) & credit;
        busy      = (state_q != ST_IDLE) & (state_q != ST_DONE);
        test_done = (state_q == ST_DONE);
    end

    always_comb begin
        cfg_addr_d      = cfg_addr_q;
        ecg_addr_d      = ecg_addr_q;
        inflight_d      = inflight_q;
        inflight_cfg_d  = inflight_cfg_q;
        inflight_last_d = inflight_last_q;
        loop_d          = loop_q;
        ipass_d         = ipass_q;
        pass_cnt_d      = pass_cnt_q;
        if (abort) begin
            cfg_addr_d      = CFG_AW'(CFG_STR);
            ecg_addr_d      = ECG_AW'(ECG_STR);
            inflight_d      = 1'b0;
            inflight_cfg_d  = 1'b0;
            inflight_last_d = 1'b0;
        end else begin
            inflight_d      = cfg_rd_en | ecg_rd_en;
            inflight_cfg_d  = cfg_rd_en;
            inflight_last_d = ecg_end_issue;
            if (start) begin
                cfg_addr_d = CFG_AW'(CFG_STR);
                ecg_addr_d = ECG_AW'(ECG_STR);
                loop_d     = loop_cnt;
                ipass_d    = '0;
                pass_cnt_d = '0;
            end
            if (cfg_rd_en) begin
                cfg_addr_d = cfg_end_issue ? CFG_AW'(CFG_STR) : cfg_addr_q + CFG_AW'(1);
            end
            if (ecg_rd_en) begin
                ecg_addr_d = ecg_end_issue ? ECG_AW'(ECG_STR) : ecg_addr_q + ECG_AW'(1);
                if (ecg_end_issue) ipass_d = ipass_q + LOOP_W'(1);
            end
            if (pop && out_last && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + LOOP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_addr_q      <= CFG_AW'(CFG_STR);
            ecg_addr_q      <= ECG_AW'(ECG_STR);
            inflight_q      <= 1'b0;
            inflight_cfg_q  <= 1'b0;
            inflight_last_q <= 1'b0;
            loop_q          <= '0;
            ipass_q         <= '0;
            pass_cnt_q      <= '0;
        end else begin
            cfg_addr_q      <= cfg_addr_d;
            ecg_addr_q      <= ecg_addr_d;
            inflight_q      <= inflight_d;
            inflight_cfg_q  <= inflight_cfg_d;
            inflight_last_q <= inflight_last_d;
            loop_q          <= loop_d;
            ipass_q         <= ipass_d;
            pass_cnt_q      <= pass_cnt_d;
        end
    end

    // A response landing in the abort cycle is dropped rather than buffered.
    assign push    = inflight_q & ~abort;
    assign wr_tag  = '{is_cfg: inflight_cfg_q, last: inflight_last_q};
    assign wr_word = {wr_tag, (inflight_cfg_q ? cfg_q : ecg_q)};

    stream_buf #(
        .WIDTH (WORD_W),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (abort),
        .push_i  (push),
        .wdata_i (wr_word),
        .pop_i   (pop),
        .rdata_o (head_word),
        .empty_o (buf_empty),
        .count_o (occ)
    );

    assign head_tag   = tag_t'(head_word[WORD_W-1 -: TAG_W]);
    assign out_valid  = ~buf_empty;
    assign out_data   = out_valid ? head_word[DATA_W-1:0] : '0;
    assign out_is_cfg = out_valid & head_tag.is_cfg;
    assign out_last   = out_valid & head_tag.last;
    assign cfg_addr   = cfg_addr_q;
    assign ecg_addr   = ecg_addr_q;
    assign pass_cnt   = pass_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_test_stream_ctrl.sv
// Bench for test_stream_ctrl: vector table of runs plus hand sequences for
// abort, re-arm and asynchronous reset; stream words checked by scoreboard.
`default_nettype none

module tb_test_stream_ctrl;

    localparam int DATA_W = 16;
    localparam int CFG_AW = 10;
    localparam int ECG_AW = 13;
    localparam int LOOP_W = 8;
    localparam int DEPTH  = 4;
    localparam int CFG_N  = 4;
    localparam int ECG_N  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              test_en = 1'b0;
    logic              abort = 1'b0;
    logic [LOOP_W-1:0] loop_cnt = '0;
    logic              cfg_rd_en, ecg_rd_en;
    logic [CFG_AW-1:0] cfg_addr;
    logic [ECG_AW-1:0] ecg_addr;
    logic [DATA_W-1:0] cfg_q = '0;
    logic [DATA_W-1:0] ecg_q = '0;
    logic              out_valid, out_is_cfg, out_last, busy, test_done;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [LOOP_W-1:0] pass_cnt;

    test_stream_ctrl #(
        .DATA_W(DATA_W), .CFG_AW(CFG_AW), .ECG_AW(ECG_AW),
        .CFG_STR(0), .CFG_END(CFG_N-1), .ECG_STR(0), .ECG_END(ECG_N-1),
        .LOOP_W(LOOP_W), .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .test_en(test_en), .abort(abort),
        .loop_cnt(loop_cnt), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
        .cfg_q(cfg_q), .ecg_rd_en(ecg_rd_en), .ecg_addr(ecg_addr), .ecg_q(ecg_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_cfg(out_is_cfg), .out_last(out_last), .busy(busy),
        .test_done(test_done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // Memory contents: config word = 0x100 + address, ECG word = address.
    always @(posedge clk) begin
        if (cfg_rd_en) cfg_q <= 16'h0100 + DATA_W'(cfg_addr);
        if (ecg_rd_en) ecg_q <= DATA_W'(ecg_addr);
    end

    typedef struct packed {
        logic              is_cfg;
        logic              last;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef struct {
        logic [LOOP_W-1:0] loops;
        int                rmode;
        int                exp_words;
        int                exp_passes;
    } vec_t;

    word_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    int    rcnt = 0;
    int    outstanding = 0;
    int    max_out = 0;
    int    words_seen = 0;
    int    last_pop_cyc = 0;
    int    done_cyc = 0;
    logic  prev_stall = 1'b0;
    logic  prev_abort = 1'b0;
    word_t prev_w = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Downstream ready: 0 = always ready, 1 = pattern 1,0,0,1, other = stalled.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            default: out_ready = 1'b0;
        endcase
        rcnt++;
    end

    always @(negedge clk) begin
        word_t w, e;
        if (!reset_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
            prev_abort  = 1'b0;
        end else begin
            w = {out_is_cfg, out_last, out_data};
            if (prev_stall && !prev_abort) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_stable", 32'(w), 32'(prev_w));
            end
            if (out_valid && out_ready) begin
                words_seen++;
                if (out_last) last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", w);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_word", 32'(w), 32'(e));
                end
            end
            if (abort) outstanding = 0;
            else outstanding = outstanding + int'(cfg_rd_en | ecg_rd_en) - int'(out_valid & out_ready);
            if (outstanding > max_out) max_out = outstanding;
            prev_stall = out_valid && !out_ready;
            prev_w     = w;
            prev_abort = abort;
        end
    end

    task automatic push_expected(input int loops);
        for (int i = 0; i < CFG_N; i++) exp_q.push_back({1'b1, 1'b0, DATA_W'(16'h0100 + i)});
        for (int p = 0; p < loops; p++)
            for (int e = 0; e < ECG_N; e++) exp_q.push_back({1'b0, (e == ECG_N-1), DATA_W'(e)});
    endtask

    // Raise test_en so edge k samples it; check reads start in k+1, data in k+3.
    task automatic start_run(input logic [LOOP_W-1:0] loops);
        loop_cnt = loops;
        @(posedge clk); #1;
        test_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_rd_en_k1", 32'(cfg_rd_en), 32'd1);
        check("lat_cfg_addr_k1", 32'(cfg_addr), 32'd0);
        @(negedge clk);
        check("lat_valid_k2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid_k3", 32'(out_valid), 32'd1);
        check("first_word", 32'({out_is_cfg, out_data}), 32'h10100);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!test_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        check("done_timeout", 32'(test_done), 32'd1);
    endtask

    task automatic drop_test_en();
        @(posedge clk); #1;
        test_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rearm_idle_done", 32'(test_done), 32'd0);
        check("rearm_idle_busy", 32'(busy), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{loops: 8'd1, rmode: 0, exp_words: 12, exp_passes: 1};
        vecs[1] = '{loops: 8'd1, rmode: 1, exp_words: 12, exp_passes: 1};
        vecs[2] = '{loops: 8'd3, rmode: 0, exp_words: 28, exp_passes: 3};
        vecs[3] = '{loops: 8'd2, rmode: 1, exp_words: 20, exp_passes: 2};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(test_done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_strobes", 32'({cfg_rd_en, ecg_rd_en}), 32'd0);
        check("rst_addrs", 32'({cfg_addr, ecg_addr}), 32'd0);
        check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            ready_mode = vecs[i].rmode;
            words_seen = 0;
            max_out    = 0;
            push_expected(vecs[i].loops);
            start_run(vecs[i].loops);
            wait_done(3000);
            check("pass_cnt", 32'(pass_cnt), 32'(vecs[i].exp_passes));
            check("word_count", 32'(words_seen), 32'(vecs[i].exp_words));
            check("queue_empty", 32'(exp_q.size()), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
            check("done_after_last", 32'(done_cyc - last_pop_cyc), 32'd2);
            check("credit_bound", 32'(max_out <= DEPTH), 32'd1);
            repeat (4) @(negedge clk);
            check("no_restart_done", 32'(test_done), 32'd1);
            check("no_restart_rd", 32'({cfg_rd_en, busy}), 32'd0);
            exp_q.delete();
            drop_test_en();
        end

        // Endless replay, abort after five completed passes.
        ready_mode = 0;
        push_expected(7);
        start_run(8'd0);
        begin
            int n = 0;
            while (pass_cnt != 8'd5 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        check("inf_reach5", 32'(pass_cnt), 32'd5);
        check("inf_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        abort   = 1'b1;
        test_en = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_addrs", 32'({cfg_addr, ecg_addr}), 32'd0);
        check("abort_pass_hold", 32'(pass_cnt), 32'd5);
        repeat (3) @(negedge clk);
        check("abort_idle_stay", 32'({busy, test_done, out_valid}), 32'd0);
        exp_q.delete();

        // Abort while the buffer is full and a response is in flight.
        ready_mode = 2;
        repeat (2) @(negedge clk);
        max_out = 0;
        start_run(8'd1);
        @(posedge clk);
        @(posedge clk); #1;
        abort   = 1'b1;
        test_en = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("full_credit", 32'(max_out), 32'(DEPTH));
        check("full_abort_valid", 32'(out_valid), 32'd0);
        ready_mode = 0;
        repeat (3) @(negedge clk);
        words_seen = 0;
        push_expected(1);
        start_run(8'd1);
        wait_done(3000);
        check("restart_words", 32'(words_seen), 32'd12);
        check("restart_queue", 32'(exp_q.size()), 32'd0);
        check("restart_pass", 32'(pass_cnt), 32'd1);
        drop_test_en();

        // Asynchronous reset in the middle of a run.
        push_expected(1);
        start_run(8'd1);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_rd", 32'(cfg_rd_en | ecg_rd_en), 32'd0);
        check("async_rst_pass", 32'(pass_cnt), 32'd0);
        test_en = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
